l1_dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and the L2.
- Accepts word-granular CPU requests with byte strobes.
- Issues full-line reads (refills) and full-line writes (dirty writebacks) on a line interface that connects directly to the L2 upper port.
- Blocking: one outstanding CPU request at a time.

---
 rtl/l1_dcache.sv | 188 ++++++++++++++++++
 tb/tb_l1_dcache.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache with line-wide L2 port.
// Define L1_STATS_EN to add saturating hit_cnt/miss_cnt ports.
module l1_dcache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 16,
  localparam int LINE_W    = LINE_BYTES * 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  input  logic [DATA_W/8-1:0] cpu_req_wstrb,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_resp_rdata,
  output logic                l2_req_valid,
  input  logic                l2_req_ready,
  output logic                l2_req_rw,
  output logic [ADDR_W-1:0]   l2_req_addr,
  output logic [LINE_W-1:0]   l2_req_wline,
  input  logic                l2_resp_valid,
  input  logic [LINE_W-1:0]   l2_resp_rline
`ifdef L1_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BO_W  = $clog2(NB);
  localparam int WS_W  = OFF_W - BO_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, REFILL_REQ, REFILL_WAIT, RESP
  } state_t;

  state_t              state;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       wstrb_q;
  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [LINE_W-1:0]   data_q [SETS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WS_W-1:0]     wsel;
  logic                unused_bo;
  logic                hit;
  logic                fill;
  logic                we;
  logic [LINE_W-1:0]   line_in;
  logic [LINE_W-1:0]   line_wr;
  logic [DATA_W-1:0]   word;

  assign idx           = addr_q[OFF_W +: IDX_W];
  assign tag           = addr_q[ADDR_W-1 -: TAG_W];
  assign wsel          = addr_q[BO_W +: WS_W];
  assign unused_bo     = ^addr_q[BO_W-1:0];
  assign cpu_req_ready = (state == IDLE);

  // Refill data and stored data share one merge path
  always_comb begin
    line_in = (state == REFILL_WAIT) ? l2_resp_rline : data_q[idx];
    line_wr = line_in;
    if (rw_q) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_q[b])
          line_wr[int'(wsel)*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end
    word = line_in[int'(wsel)*DATA_W +: DATA_W];
    hit  = valid_q[idx] && (tag_q[idx] == tag);
    fill = (state == REFILL_WAIT) && l2_resp_valid;
    we   = fill || ((state == LOOKUP) && hit && rw_q);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      data_q[idx] <= line_wr;
      tag_q[idx]  <= tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      l2_req_valid   <= 1'b0;
      l2_req_rw      <= 1'b0;
      l2_req_addr    <= '0;
      l2_req_wline   <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            rw_q    <= cpu_req_rw;
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            wstrb_q <= cpu_req_wstrb;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (rw_q) dirty_q[idx] <= 1'b1;
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= rw_q ? '0 : word;
            state          <= RESP;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            l2_req_valid <= 1'b1;
            l2_req_rw    <= 1'b1;
            l2_req_addr  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
            l2_req_wline <= data_q[idx];
            state        <= WB_REQ;
          end else begin
            l2_req_valid <= 1'b1;
            l2_req_rw    <= 1'b0;
            l2_req_addr  <= {tag, idx, {OFF_W{1'b0}}};
            state        <= REFILL_REQ;
          end
        end
        WB_REQ: begin
          if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
            dirty_q[idx] <= 1'b0;
            state        <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          // After a writeback valid drops for a cycle before the read
          if (!l2_req_valid) begin
            l2_req_valid <= 1'b1;
            l2_req_rw    <= 1'b0;
            l2_req_addr  <= {tag, idx, {OFF_W{1'b0}}};
          end else if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
            state        <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (l2_resp_valid) begin
            valid_q[idx]   <= 1'b1;
            dirty_q[idx]   <= rw_q;
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= rw_q ? '0 : word;
            state          <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && (hit_cnt != '1))
        hit_cnt <= hit_cnt + 32'd1;
      if (!hit && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: flat-memory reference model plus L2 responder.
// Stats checks are compiled in when L1_STATS_EN is defined.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_ready;
  logic         cpu_req_rw = 1'b0;
  logic [31:0]  cpu_req_addr = '0;
  logic [31:0]  cpu_req_wdata = '0;
  logic [3:0]   cpu_req_wstrb = '0;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         l2_req_valid;
  logic         l2_req_ready;
  logic         l2_req_rw;
  logic [31:0]  l2_req_addr;
  logic [255:0] l2_req_wline;
  logic         l2_resp_valid;
  logic [255:0] l2_resp_rline;
`ifdef L1_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_rw(l2_req_rw), .l2_req_addr(l2_req_addr),
    .l2_req_wline(l2_req_wline),
    .l2_resp_valid(l2_resp_valid), .l2_resp_rline(l2_resp_rline)
`ifdef L1_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  // Reference: flat word memory (CPU view) and L2 contents
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] l2mem   [logic [31:0]];

  function automatic logic [31:0] init_w(input logic [31:0] a);
    return ((a & 32'hFFFF_FFE0) << 6) + ((a >> 2) & 32'd7);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : init_w(w);
  endfunction

  function automatic logic [31:0] l2_get(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return l2mem.exists(w) ? l2mem[w] : init_w(w);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = ref_get({a[31:5], 5'b0} + 32'(4*i));
    return l;
  endfunction

  function automatic logic [255:0] l2_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = l2_get({a[31:5], 5'b0} + 32'(4*i));
    return l;
  endfunction

  // Abstract tag model: which line each set holds and whether modified
  bit          mv [16];
  logic [22:0] mt [16];
  bit          md [16];
  int          m_hits = 0;
  int          m_miss = 0;

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] last_wr = '0;
  bit          refill_owed = 1'b0;
  int          force_stall = -1;
  int          force_dly = -1;

  logic [31:0] exp_q [$];

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cpu_resp_valid) begin
        chk("resp_before_refill", 256'(refill_owed), 256'(0));
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL resp_unexpected: got rdata 0x%0h with none pending",
                   cpu_resp_rdata);
        end else begin
          chk("resp_rdata", 256'(cpu_resp_rdata), 256'(exp_q.pop_front()));
        end
      end
    end
  end

  // L2 responder with stall and latency knobs
  initial begin
    bit           seen;
    logic         cap_rw;
    logic [31:0]  cap_addr;
    logic [255:0] cap_line;
    int           stall_left;
    bit           pend;
    logic [31:0]  pend_addr;
    int           pend_dly;
    seen = 0; pend = 0; stall_left = 0; pend_dly = 0;
    cap_rw = 0; cap_addr = '0; cap_line = '0; pend_addr = '0;
    l2_req_ready = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_rline = '0;
    forever begin
      @(negedge clk);
      l2_resp_valid = 1'b0;
      if (!rst_n) begin
        seen = 0; pend = 0; l2_req_ready = 1'b0;
      end else begin
        if (seen && l2_req_ready) begin
          if (cap_rw) begin
            wr_cnt++;
            last_wr = cap_addr;
            chk("wb_align", 256'(cap_addr[4:0]), 256'(0));
            chk("wb_line", cap_line, ref_line(cap_addr));
            for (int i = 0; i < 8; i++)
              l2mem[{cap_addr[31:5], 5'b0} + 32'(4*i)] = cap_line[i*32 +: 32];
          end else begin
            rd_cnt++;
            last_rd = cap_addr;
            chk("rd_align", 256'(cap_addr[4:0]), 256'(0));
            pend = 1;
            pend_addr = cap_addr;
            pend_dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
          end
        end else if (seen) begin
          chk("stall_valid", 256'(l2_req_valid), 256'(1));
          chk("stall_rw", 256'(l2_req_rw), 256'(cap_rw));
          chk("stall_addr", 256'(l2_req_addr), 256'(cap_addr));
          chk("stall_wline", l2_req_wline, cap_line);
        end
        if (pend) begin
          if (pend_dly == 0) begin
            l2_resp_valid = 1'b1;
            l2_resp_rline = l2_line(pend_addr);
            refill_owed = 1'b0;
            pend = 0;
          end else begin
            pend_dly--;
          end
        end
        if (l2_req_valid) begin
          if (!seen || l2_req_ready) begin
            stall_left = (force_stall >= 0) ? force_stall
                                            : int'($urandom_range(0, 2));
            force_stall = -1;
          end
          l2_req_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
          seen = 1;
          cap_rw = l2_req_rw;
          cap_addr = l2_req_addr;
          cap_line = l2_req_wline;
        end else begin
          l2_req_ready = 1'b0;
          seen = 0;
        end
      end
    end
  end

  task automatic cpu_op(input bit rw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input bit wait_done = 1);
    logic [3:0]  idx;
    logic [22:0] tg;
    logic [31:0] w;
    bit          hit;
    bit          exp_wb;
    int          rd0;
    int          wr0;
    int          cyc;
    idx = a[8:5];
    tg = a[31:9];
    hit = mv[idx] && (mt[idx] == tg);
    exp_wb = !hit && mv[idx] && md[idx];
    if (hit) m_hits++;
    else m_miss++;
    if (!hit) begin
      mv[idx] = 1; mt[idx] = tg; md[idx] = 0;
    end
    if (rw) begin
      md[idx] = 1;
      w = ref_get(a);
      for (int b = 0; b < 4; b++)
        if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[{a[31:2], 2'b00}] = w;
      exp_q.push_back(32'd0);
    end else begin
      exp_q.push_back(ref_get(a));
    end
    refill_owed = !hit;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    cyc = 0;
    @(negedge clk);
    while (!cpu_req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!cpu_req_ready) begin
      n_chk++;
      $display("FAIL req_ready_timeout: ready=0 after %0d cycles", cyc);
    end
    cpu_req_valid = 1'b1;
    cpu_req_rw = rw;
    cpu_req_addr = a;
    cpu_req_wdata = wd;
    cpu_req_wstrb = ws;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    if (!wait_done) return;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL resp_timeout: addr 0x%0h got no response, want one", a);
      exp_q.delete();
    end
    chk("l2_reads", 256'(rd_cnt - rd0), 256'(hit ? 0 : 1));
    chk("l2_writes", 256'(wr_cnt - wr0), 256'(exp_wb));
`ifdef L1_STATS_EN
    chk("hit_cnt", 256'(hit_cnt), 256'(m_hits));
    chk("miss_cnt", 256'(miss_cnt), 256'(m_miss));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int cyc;
    logic [31:0] a;
    @(negedge clk);
    chk("rst_l2_valid", 256'(l2_req_valid), 256'(0));
    chk("rst_l2_addr", 256'(l2_req_addr), 256'(0));
    chk("rst_l2_rw", 256'(l2_req_rw), 256'(0));
    chk("rst_l2_wline", l2_req_wline, 256'(0));
    chk("rst_resp_valid", 256'(cpu_resp_valid), 256'(0));
    chk("rst_resp_rdata", 256'(cpu_resp_rdata), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 256'(cpu_req_ready), 256'(1));
`ifdef L1_STATS_EN
    chk("rst_hit_cnt", 256'(hit_cnt), 256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));
`endif

    cpu_op(0, 32'h40, 0, 0);
    chk("refill_addr_40", 256'(last_rd), 256'(32'h40));
    cpu_op(0, 32'h44, 0, 0);
    cpu_op(1, 32'h48, 32'hDEAD_BEEF, 4'b0011);
    cpu_op(0, 32'h48, 0, 0);
    cpu_op(0, 32'h240, 0, 0);
    chk("wb_addr_40", 256'(last_wr), 256'(32'h40));
    chk("refill_addr_240", 256'(last_rd), 256'(32'h240));
    cpu_op(1, 32'h80, 32'hA5A5_A5A5, 4'b1111);
    cpu_op(0, 32'h80, 0, 0);
    cpu_op(0, 32'h480, 0, 0);
    chk("wb_addr_80", 256'(last_wr), 256'(32'h80));
    cpu_op(1, 32'h4C0, 32'h1234_5678, 4'b0000);
    cpu_op(0, 32'h4C0, 0, 0);

    force_stall = 5;
    cpu_op(0, 32'h100, 0, 0);

    cpu_op(0, 32'h44, 0, 0);
    force_dly = 40;
    rd0 = rd_cnt;
    cpu_op(0, 32'h420, 0, 0, 0);
    cyc = 0;
    while (rd_cnt == rd0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (rd_cnt == rd0) begin
      n_chk++;
      $display("FAIL refill_req_timeout: no read after %0d cycles", cyc);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_l2_valid", 256'(l2_req_valid), 256'(0));
    chk("midrst_resp_valid", 256'(cpu_resp_valid), 256'(0));
    exp_q.delete();
    refill_owed = 1'b0;
    force_dly = -1;
    ref_mem = l2mem;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; md[i] = 0;
    end
    m_hits = 0;
    m_miss = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 256'(cpu_req_ready), 256'(1));
    cpu_op(0, 32'h44, 0, 0);
    cpu_op(0, 32'h44, 0, 0);
    cpu_op(0, 32'h48, 0, 0);

    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) force_stall = int'($urandom_range(3, 6));
      cpu_op(1'($urandom_range(0, 1)), a, $urandom,
             4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
